// File: rtl/iot_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : iot_event_arbiter
// Purpose  : Round-robin arbiter that serialises on/off events from N_DEV
//            IoT devices into single-cycle change/on_off commands for the
//            active-device monitor. Keeps a per-device active bitmap to
//            filter redundant events and a shadow count of active devices.
// Option   : ARB_DROP_CNT_EN adds o_drop_cnt, a saturating count of
//            redundant events dropped during arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module iot_event_arbiter #(
   parameter int N_DEV      = 4,
   parameter int ID_W       = 2,
   parameter int GAP_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic [N_DEV-1:0] i_ev_valid,
   input  logic [N_DEV-1:0] i_ev_on,
   output logic [N_DEV-1:0] o_ev_ready,
   output logic             o_change,
   output logic             o_on_off,
   output logic [ID_W-1:0]  o_grant_id,
   output logic [N_DEV-1:0] o_dev_active,
   output logic [7:0]       o_active_cnt,
   output logic             o_busy
`ifdef ARB_DROP_CNT_EN
  ,output logic [7:0]       o_drop_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARB   = 2'd1,
      S_ISSUE = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   localparam logic [2:0] c_GAP_LAST = 3'(GAP_CYCLES - 1);

   state_t            r_state;
   logic [ID_W-1:0]   r_rr_ptr;
   logic [ID_W-1:0]   r_grant_id;
   logic [N_DEV-1:0]  r_dev_active;
   logic [7:0]        r_active_cnt;
   logic              r_change;
   logic              r_on_off;
   logic              r_ev_on_lat;
   logic [2:0]        r_gap_cnt;

   logic              w_found;
   logic [ID_W-1:0]   w_winner;
   logic [ID_W-1:0]   w_next_ptr;
   logic              w_win_on;
   logic              w_redundant;
   logic              w_accept;
   logic [N_DEV-1:0]  w_ready;

   // Index of the requester at a given offset from base, wrapping at N_DEV
   // (N_DEV need not be a power of two).
   function automatic logic [ID_W-1:0] f_wrap(input logic [ID_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= N_DEV) s = s - N_DEV;
      return ID_W'(s);
   endfunction

   // Round-robin search: descending scan so the lowest offset from rr_ptr wins.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int k = N_DEV - 1; k >= 0; k--) begin
         if (i_ev_valid[f_wrap(r_rr_ptr, k)]) begin
            w_found  = 1'b1;
            w_winner = f_wrap(r_rr_ptr, k);
         end
      end
   end

   assign w_next_ptr  = (w_winner == ID_W'(N_DEV - 1)) ? '0 : w_winner + ID_W'(1);
   assign w_win_on    = i_ev_on[w_winner];
   assign w_redundant = (i_ev_on[w_winner] == r_dev_active[w_winner]);
   assign w_accept    = (r_state == S_ARB) && i_en && w_found;

   // One-hot acceptance strobe, only ever raised in ARB (the sole combinational path).
   always_comb begin
      w_ready = '0;
      if (w_accept) w_ready[w_winner] = 1'b1;
   end

   // Main control FSM with registered command outputs and shadow bitmap/count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_rr_ptr     <= '0;
         r_grant_id   <= '0;
         r_dev_active <= '0;
         r_active_cnt <= 8'd0;
         r_change     <= 1'b0;
         r_on_off     <= 1'b0;
         r_ev_on_lat  <= 1'b0;
         r_gap_cnt    <= 3'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_en) r_state <= S_ARB;
            end
            S_ARB: begin
               if (!i_en) begin
                  r_state <= S_IDLE;
               end else if (w_found) begin
                  r_grant_id  <= w_winner;
                  r_rr_ptr    <= w_next_ptr;
                  r_ev_on_lat <= w_win_on;
                  // Redundant events are consumed here without a command.
                  if (!w_redundant) begin
                     r_state  <= S_ISSUE;
                     r_change <= 1'b1;
                     r_on_off <= w_win_on;
                  end
               end
            end
            S_ISSUE: begin
               r_dev_active[r_grant_id] <= ~r_dev_active[r_grant_id];
               r_active_cnt <= r_ev_on_lat ? r_active_cnt + 8'd1 : r_active_cnt - 8'd1;
               r_change     <= 1'b0;
               r_on_off     <= 1'b0;
               r_gap_cnt    <= 3'd0;
               r_state      <= S_GAP;
            end
            S_GAP: begin
               // en is deliberately ignored so an issued command always completes.
               if (r_gap_cnt == c_GAP_LAST) begin
                  r_gap_cnt <= 3'd0;
                  r_state   <= S_ARB;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 3'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef ARB_DROP_CNT_EN
   logic [7:0] r_drop_cnt;

   // Saturating count of redundant events filtered during arbitration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_drop_cnt <= 8'd0;
      end else if (w_accept && w_redundant && (r_drop_cnt != 8'hFF)) begin
         r_drop_cnt <= r_drop_cnt + 8'd1;
      end
   end

   assign o_drop_cnt = r_drop_cnt;
`endif

   assign o_ev_ready   = w_ready;
   assign o_change     = r_change;
   assign o_on_off     = r_on_off;
   assign o_grant_id   = r_grant_id;
   assign o_dev_active = r_dev_active;
   assign o_active_cnt = r_active_cnt;
   assign o_busy       = (r_state == S_ISSUE) || (r_state == S_GAP);

endmodule
`default_nettype wire

// File: tb/tb_iot_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_iot_event_arbiter
// Purpose  : Self-checking bench for iot_event_arbiter (N_DEV=4, GAP=1).
//            Per-cycle vector table plus a reset-during-ISSUE sequence.
//            Build with ARB_DROP_CNT_EN defined to also check o_drop_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iot_event_arbiter;

   logic       clk;
   logic       rst;
   logic       i_en;
   logic [3:0] i_ev_valid;
   logic [3:0] i_ev_on;
   logic [3:0] o_ev_ready;
   logic       o_change;
   logic       o_on_off;
   logic [1:0] o_grant_id;
   logic [3:0] o_dev_active;
   logic [7:0] o_active_cnt;
   logic       o_busy;
`ifdef ARB_DROP_CNT_EN
   logic [7:0] o_drop_cnt;
`endif

   int n_pass  = 0;
   int n_total = 0;

   iot_event_arbiter #(.N_DEV(4), .ID_W(2), .GAP_CYCLES(1)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .i_en         (i_en),
      .i_ev_valid   (i_ev_valid),
      .i_ev_on      (i_ev_on),
      .o_ev_ready   (o_ev_ready),
      .o_change     (o_change),
      .o_on_off     (o_on_off),
      .o_grant_id   (o_grant_id),
      .o_dev_active (o_dev_active),
      .o_active_cnt (o_active_cnt),
      .o_busy       (o_busy)
`ifdef ARB_DROP_CNT_EN
     ,.o_drop_cnt   (o_drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model of the downstream monitor counter driven by the command strobe.
   int mon_cnt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           mon_cnt <= 0;
      else if (o_change) mon_cnt <= o_on_off ? mon_cnt + 1 : mon_cnt - 1;
   end

   typedef struct {
      logic       rst;
      logic       en;
      logic [3:0] v;
      logic [3:0] on;
      logic [3:0] rdy;
      logic       chg;
      logic       oo;
      logic [1:0] gid;
      logic [3:0] act;
      logic [7:0] cnt;
      logic       busy;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic e, input logic [3:0] v,
                               input logic [3:0] on, input logic [3:0] rdy,
                               input logic chg, input logic oo, input logic [1:0] gid,
                               input logic [3:0] act, input logic [7:0] cnt,
                               input logic busy);
      vec_t t;
      t.rst = r; t.en = e; t.v = v; t.on = on; t.rdy = rdy; t.chg = chg;
      t.oo = oo; t.gid = gid; t.act = act; t.cnt = cnt; t.busy = busy;
      return t;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] got,
                      input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s (step %0d): got 0x%0h expected 0x%0h", name, idx, got, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int found;
      rst = 1'b1; i_en = 1'b0; i_ev_valid = 4'h0; i_ev_on = 4'h0;

      //            rst en  v    on   | rdy  chg oo gid act  cnt busy
      // reset for two cycles
      tbl.push_back(mk(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0));
      tbl.push_back(mk(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0));
      // single on event from device 2
      tbl.push_back(mk(0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0));
      tbl.push_back(mk(0, 1, 4'h4, 4'h4, 4'h4, 0, 0, 0, 4'h0, 0, 0));
      tbl.push_back(mk(0, 1, 4'h0, 4'h0, 4'h0, 1, 1, 2, 4'h0, 0, 1));
      tbl.push_back(mk(0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 2, 4'h4, 1, 1));
      tbl.push_back(mk(0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 2, 4'h4, 1, 0));
      // contention: all four request on, grant order 0,1,2,3
      tbl.push_back(mk(1, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0));
      tbl.push_back(mk(0, 1, 4'hF, 4'hF, 4'h0, 0, 0, 0, 4'h0, 0, 0));
      tbl.push_back(mk(0, 1, 4'hF, 4'hF, 4'h1, 0, 0, 0, 4'h0, 0, 0));
      tbl.push_back(mk(0, 1, 4'hE, 4'hF, 4'h0, 1, 1, 0, 4'h0, 0, 1));
      tbl.push_back(mk(0, 1, 4'hE, 4'hF, 4'h0, 0, 0, 0, 4'h1, 1, 1));
      tbl.push_back(mk(0, 1, 4'hE, 4'hF, 4'h2, 0, 0, 0, 4'h1, 1, 0));
      tbl.push_back(mk(0, 1, 4'hC, 4'hF, 4'h0, 1, 1, 1, 4'h1, 1, 1));
      tbl.push_back(mk(0, 1, 4'hC, 4'hF, 4'h0, 0, 0, 1, 4'h3, 2, 1));
      tbl.push_back(mk(0, 1, 4'hC, 4'hF, 4'h4, 0, 0, 1, 4'h3, 2, 0));
      tbl.push_back(mk(0, 1, 4'h8, 4'hF, 4'h0, 1, 1, 2, 4'h3, 2, 1));
      tbl.push_back(mk(0, 1, 4'h8, 4'hF, 4'h0, 0, 0, 2, 4'h7, 3, 1));
      tbl.push_back(mk(0, 1, 4'h8, 4'hF, 4'h8, 0, 0, 2, 4'h7, 3, 0));
      tbl.push_back(mk(0, 1, 4'h0, 4'hF, 4'h0, 1, 1, 3, 4'h7, 3, 1));
      tbl.push_back(mk(0, 1, 4'h0, 4'hF, 4'h0, 0, 0, 3, 4'hF, 4, 1));
      tbl.push_back(mk(0, 1, 4'h0, 4'hF, 4'h0, 0, 0, 3, 4'hF, 4, 0));
      // redundant: device 1 on, then on again (strobed but no command)
      tbl.push_back(mk(1, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0));
      tbl.push_back(mk(0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0));
      tbl.push_back(mk(0, 1, 4'h2, 4'h2, 4'h2, 0, 0, 0, 4'h0, 0, 0));
      tbl.push_back(mk(0, 1, 4'h0, 4'h0, 4'h0, 1, 1, 1, 4'h0, 0, 1));
      tbl.push_back(mk(0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 1, 4'h2, 1, 1));
      tbl.push_back(mk(0, 1, 4'h2, 4'h2, 4'h2, 0, 0, 1, 4'h2, 1, 0));
      tbl.push_back(mk(0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 1, 4'h2, 1, 0));
      tbl.push_back(mk(0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 1, 4'h2, 1, 0));
      // off event: device 3 on, then off (decrement command)
      tbl.push_back(mk(0, 1, 4'h8, 4'h8, 4'h8, 0, 0, 1, 4'h2, 1, 0));
      tbl.push_back(mk(0, 1, 4'h0, 4'h0, 4'h0, 1, 1, 3, 4'h2, 1, 1));
      tbl.push_back(mk(0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 3, 4'hA, 2, 1));
      tbl.push_back(mk(0, 1, 4'h8, 4'h0, 4'h8, 0, 0, 3, 4'hA, 2, 0));
      tbl.push_back(mk(0, 1, 4'h0, 4'h0, 4'h0, 1, 0, 3, 4'hA, 2, 1));
      tbl.push_back(mk(0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 3, 4'h2, 1, 1));
      // enable handling: en=0 returns to IDLE, IDLE never grants, GAP ignores en
      tbl.push_back(mk(0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 3, 4'h2, 1, 0));
      tbl.push_back(mk(0, 0, 4'h4, 4'h4, 4'h0, 0, 0, 3, 4'h2, 1, 0));
      tbl.push_back(mk(0, 1, 4'h4, 4'h4, 4'h0, 0, 0, 3, 4'h2, 1, 0));
      tbl.push_back(mk(0, 1, 4'h4, 4'h4, 4'h4, 0, 0, 3, 4'h2, 1, 0));
      tbl.push_back(mk(0, 1, 4'h0, 4'h0, 4'h0, 1, 1, 2, 4'h2, 1, 1));
      tbl.push_back(mk(0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 2, 4'h6, 2, 1));
      tbl.push_back(mk(0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 2, 4'h6, 2, 0));

      // Apply one row per cycle on the falling edge, check 1 ns later.
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rst = tbl[i].rst; i_en = tbl[i].en;
         i_ev_valid = tbl[i].v; i_ev_on = tbl[i].on;
         #1;
         chk("ev_ready",   i, 32'(o_ev_ready),   32'(tbl[i].rdy));
         chk("change",     i, 32'(o_change),     32'(tbl[i].chg));
         chk("on_off",     i, 32'(o_on_off),     32'(tbl[i].oo));
         chk("grant_id",   i, 32'(o_grant_id),   32'(tbl[i].gid));
         chk("dev_active", i, 32'(o_dev_active), 32'(tbl[i].act));
         chk("active_cnt", i, 32'(o_active_cnt), 32'(tbl[i].cnt));
         chk("busy",       i, 32'(o_busy),       32'(tbl[i].busy));
         chk("monitor_vs_cnt", i, 32'(o_active_cnt), 32'(mon_cnt));
      end
`ifdef ARB_DROP_CNT_EN
      chk("drop_cnt", 100, 32'(o_drop_cnt), 32'd1);
`endif

      // Reset during ISSUE aborts the command; rr_ptr restarts at 0.
      @(negedge clk); rst = 1'b1; i_en = 1'b0; i_ev_valid = 4'h0; i_ev_on = 4'h0;
      @(negedge clk); rst = 1'b0; i_en = 1'b1; i_ev_valid = 4'h1; i_ev_on = 4'h1;
      @(negedge clk); #1;
      chk("mid_rst_first_ready", 200, 32'(o_ev_ready), 32'h1);
      @(negedge clk); i_ev_valid = 4'h0; #1;
      chk("mid_rst_in_issue", 201, 32'(o_change), 32'd1);
      rst = 1'b1; #1;
      chk("mid_rst_change",     202, 32'(o_change),     32'd0);
      chk("mid_rst_on_off",     203, 32'(o_on_off),     32'd0);
      chk("mid_rst_dev_active", 204, 32'(o_dev_active), 32'h0);
      chk("mid_rst_active_cnt", 205, 32'(o_active_cnt), 32'd0);
      chk("mid_rst_busy",       206, 32'(o_busy),       32'd0);
      @(negedge clk); rst = 1'b0; i_en = 1'b1; i_ev_valid = 4'hA; i_ev_on = 4'hA; #1;
      chk("post_rst_idle_ready", 207, 32'(o_ev_ready), 32'h0);
      @(negedge clk); #1;
      chk("post_rst_dev1_first", 208, 32'(o_ev_ready), 32'h2);
      @(negedge clk); i_ev_valid = 4'h8; #1;
      chk("post_rst_issue",      209, 32'(o_change),   32'd1);
      chk("post_rst_grant_id",   210, 32'(o_grant_id), 32'd1);
      found = 0;
      for (int k = 0; k < 8 && found == 0; k++) begin
         @(negedge clk); #1;
         if (o_ev_ready == 4'h8) found = 1;
      end
      chk("dev3_grant_within_budget", 211, 32'(found), 32'd1);
      @(negedge clk); i_ev_valid = 4'h0;
      repeat (3) @(negedge clk);
      #1;
      chk("final_dev_active", 212, 32'(o_dev_active), 32'hA);
      chk("final_active_cnt", 213, 32'(o_active_cnt), 32'd2);
      chk("final_monitor",    214, 32'(mon_cnt),      32'd2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
